// File: rtl/kernel_launcher_pkg.sv
// Shared state encoding and default widths for the kernel launcher.
// KERNEL_LAUNCHER_CYCLE_COUNT_EN appends the run cycle count to the dump.
`ifndef INSTMEM_ADDR_WIDTH
`define INSTMEM_ADDR_WIDTH 8
`endif
`ifndef INST_LENGTH
`define INST_LENGTH 32
`endif
`ifndef DATAMEM_ADDR_WIDTH
`define DATAMEM_ADDR_WIDTH 8
`endif
`ifndef DATA_WORD_LENGTH
`define DATA_WORD_LENGTH 16
`endif

package kernel_launcher_pkg;

  localparam int DEF_IMEM_ADDR_W = `INSTMEM_ADDR_WIDTH;
  localparam int DEF_INST_W      = `INST_LENGTH;
  localparam int DEF_DMEM_ADDR_W = `DATAMEM_ADDR_WIDTH;
  localparam int DEF_DATA_W      = `DATA_WORD_LENGTH;

  localparam int DEF_DUMP_WORDS = 32;

`ifdef KERNEL_LAUNCHER_CYCLE_COUNT_EN
  localparam int CYC_WORDS = 2;
`else
  localparam int CYC_WORDS = 0;
`endif

  typedef enum logic [2:0] {
    S_ICNT,
    S_ILOAD,
    S_DCNT,
    S_DLOAD,
    S_RUN,
    S_DRD,
    S_DOUT
  } state_t;

endpackage

// File: rtl/kernel_launcher_mem_port_mux.sv
// Hands the IMem/DMem ports to the launcher (mem_sel=1) or to SMCore (mem_sel=0).
module kernel_launcher_mem_port_mux #(
  parameter int IMEM_ADDR_W = 8,
  parameter int INST_W      = 32,
  parameter int DMEM_ADDR_W = 8,
  parameter int DATA_W      = 16
) (
  input  logic                   mem_sel,
  input  logic                   l_imem_we,
  input  logic [IMEM_ADDR_W-1:0] l_imem_addr,
  input  logic [INST_W-1:0]      l_imem_wdata,
  input  logic                   l_dmem_we,
  input  logic [DMEM_ADDR_W-1:0] l_dmem_addr,
  input  logic [DATA_W-1:0]      l_dmem_wdata,
  input  logic [IMEM_ADDR_W-1:0] core_imem_addr,
  input  logic                   core_dmem_we,
  input  logic [DMEM_ADDR_W-1:0] core_dmem_addr,
  input  logic [DATA_W-1:0]      core_dmem_wdata,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [INST_W-1:0]      imem_wdata,
  output logic                   dmem_we,
  output logic [DMEM_ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]      dmem_wdata
);

  // SMCore only fetches from IMem, so the launcher is the sole IMem writer
  assign imem_we    = mem_sel & l_imem_we;
  assign imem_addr  = mem_sel ? l_imem_addr : core_imem_addr;
  assign imem_wdata = l_imem_wdata;

  assign dmem_we    = mem_sel ? l_dmem_we : core_dmem_we;
  assign dmem_addr  = mem_sel ? l_dmem_addr : core_dmem_addr;
  assign dmem_wdata = mem_sel ? l_dmem_wdata : core_dmem_wdata;

endmodule

// File: rtl/kernel_launcher.sv
// Loads IMem/DMem images from a host stream, runs SMCore, then dumps DMem.
// KERNEL_LAUNCHER_CYCLE_COUNT_EN adds two trailing cycle-count dump words.
module kernel_launcher
  import kernel_launcher_pkg::*;
#(
  parameter int IMEM_ADDR_W = DEF_IMEM_ADDR_W,
  parameter int INST_W      = DEF_INST_W,
  parameter int DMEM_ADDR_W = DEF_DMEM_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DUMP_WORDS  = DEF_DUMP_WORDS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic [INST_W-1:0]      host_data,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [INST_W-1:0]      imem_wdata,
  output logic                   dmem_we,
  output logic [DMEM_ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]      dmem_wdata,
  input  logic [DATA_W-1:0]      dmem_rdata,
  output logic                   mem_sel,
  output logic                   core_reset,
  input  logic                   core_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   busy,
  output logic                   cnt_err,
  input  logic [IMEM_ADDR_W-1:0] core_imem_addr,
  input  logic                   core_dmem_we,
  input  logic [DMEM_ADDR_W-1:0] core_dmem_addr,
  input  logic [DATA_W-1:0]      core_dmem_wdata
);

  localparam int DUMP_TOTAL = DUMP_WORDS + CYC_WORDS;
  localparam logic [32:0] IDEPTH = 33'd1 << IMEM_ADDR_W;
  localparam logic [32:0] DDEPTH = 33'd1 << DMEM_ADDR_W;
  localparam logic [DMEM_ADDR_W:0] LAST_IDX = (DMEM_ADDR_W+1)'(DUMP_TOTAL - 1);

  state_t state, state_nx;

  logic [31:0]            hdr, rem;
  logic [IMEM_ADDR_W:0]   icnt;
  logic [DMEM_ADDR_W:0]   dcnt;
  logic                   host_xfer, out_xfer;
  logic [DATA_W-1:0]      dump_word;

  logic                   l_imem_we, l_dmem_we;
  logic [IMEM_ADDR_W-1:0] l_imem_addr;
  logic [INST_W-1:0]      l_imem_wdata;
  logic [DMEM_ADDR_W-1:0] l_dmem_addr;
  logic [DATA_W-1:0]      l_dmem_wdata;

  assign hdr        = 32'(host_data);
  assign host_ready = (state == S_ICNT) || (state == S_ILOAD) ||
                      (state == S_DCNT) || (state == S_DLOAD);
  assign host_xfer  = host_valid && host_ready;
  assign out_xfer   = out_valid && out_ready;
  assign busy       = (state != S_ICNT);
  // The memories change hands together with the core reset, so the final
  // load write still lands during the first S_RUN cycle.
  assign mem_sel    = core_reset;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_ICNT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_ICNT:  if (host_xfer) state_nx = (hdr == '0) ? S_DCNT : S_ILOAD;
      S_ILOAD: if (host_xfer && rem == 32'd1) state_nx = S_DCNT;
      S_DCNT:  if (host_xfer) state_nx = (hdr == '0) ? S_RUN : S_DLOAD;
      S_DLOAD: if (host_xfer && rem == 32'd1) state_nx = S_RUN;
      S_RUN:   if (!core_reset && core_done) state_nx = S_DRD;
      S_DRD:   state_nx = S_DOUT;
      S_DOUT:  if (out_xfer) state_nx = (dcnt == LAST_IDX) ? S_ICNT : S_DRD;
      default: state_nx = S_ICNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem          <= '0;
      icnt         <= '0;
      dcnt         <= '0;
      l_imem_we    <= 1'b0;
      l_imem_addr  <= '0;
      l_imem_wdata <= '0;
      l_dmem_we    <= 1'b0;
      l_dmem_addr  <= '0;
      l_dmem_wdata <= '0;
      core_reset   <= 1'b1;
      cnt_err      <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
    end else begin
      l_imem_we <= 1'b0;
      l_dmem_we <= 1'b0;
      case (state)
        S_ICNT, S_DCNT: if (host_xfer) begin
          rem  <= hdr;
          icnt <= '0;
          dcnt <= '0;
          if ({1'b0, hdr} > ((state == S_ICNT) ? IDEPTH : DDEPTH)) cnt_err <= 1'b1;
        end
        // the index saturates at the depth; words beyond it are swallowed
        S_ILOAD: if (host_xfer) begin
          rem <= rem - 32'd1;
          if (!icnt[IMEM_ADDR_W]) begin
            l_imem_we    <= 1'b1;
            l_imem_addr  <= icnt[IMEM_ADDR_W-1:0];
            l_imem_wdata <= host_data;
            icnt         <= icnt + (IMEM_ADDR_W+1)'(1);
          end
        end
        S_DLOAD: if (host_xfer) begin
          rem <= rem - 32'd1;
          if (!dcnt[DMEM_ADDR_W]) begin
            l_dmem_we    <= 1'b1;
            l_dmem_addr  <= dcnt[DMEM_ADDR_W-1:0];
            l_dmem_wdata <= host_data[DATA_W-1:0];
            dcnt         <= dcnt + (DMEM_ADDR_W+1)'(1);
          end
        end
        S_RUN: begin
          if (core_reset) core_reset <= 1'b0;
          else if (core_done) begin
            core_reset  <= 1'b1;
            dcnt        <= '0;
            l_dmem_addr <= '0;
          end
        end
        S_DOUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= dump_word;
          end else if (out_ready) begin
            out_valid   <= 1'b0;
            dcnt        <= dcnt + (DMEM_ADDR_W+1)'(1);
            l_dmem_addr <= dcnt[DMEM_ADDR_W-1:0] + DMEM_ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef KERNEL_LAUNCHER_CYCLE_COUNT_EN
  localparam logic [DMEM_ADDR_W:0] CNT_LO_IDX = (DMEM_ADDR_W+1)'(DUMP_WORDS);
  localparam logic [DMEM_ADDR_W:0] CNT_HI_IDX = (DMEM_ADDR_W+1)'(DUMP_WORDS + 1);
  logic [31:0] cyc;

  always_ff @(posedge clk) begin
    if (!reset)                                    cyc <= '0;
    else if (state != S_RUN && state_nx == S_RUN) cyc <= '0;
    else if (!core_reset && !core_done)            cyc <= cyc + 32'd1;
  end

  always_comb begin
    dump_word = dmem_rdata;
    if (dcnt == CNT_LO_IDX)      dump_word = DATA_W'(cyc[15:0]);
    else if (dcnt == CNT_HI_IDX) dump_word = DATA_W'(cyc[31:16]);
  end
`else
  assign dump_word = dmem_rdata;
`endif

  kernel_launcher_mem_port_mux #(
    .IMEM_ADDR_W (IMEM_ADDR_W),
    .INST_W      (INST_W),
    .DMEM_ADDR_W (DMEM_ADDR_W),
    .DATA_W      (DATA_W)
  ) u_mux (
    .mem_sel         (mem_sel),
    .l_imem_we       (l_imem_we),
    .l_imem_addr     (l_imem_addr),
    .l_imem_wdata    (l_imem_wdata),
    .l_dmem_we       (l_dmem_we),
    .l_dmem_addr     (l_dmem_addr),
    .l_dmem_wdata    (l_dmem_wdata),
    .core_imem_addr  (core_imem_addr),
    .core_dmem_we    (core_dmem_we),
    .core_dmem_addr  (core_dmem_addr),
    .core_dmem_wdata (core_dmem_wdata),
    .imem_we         (imem_we),
    .imem_addr       (imem_addr),
    .imem_wdata      (imem_wdata),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata)
  );

endmodule

// File: tb/tb_kernel_launcher.sv
// Scoreboard bench for kernel_launcher: load, run, dump, backpressure, counts, reset.
module tb_kernel_launcher;
  localparam int IAW = 8, IW = 32, DAW = 8, DW = 16, DUMP = 32;
`ifdef KERNEL_LAUNCHER_CYCLE_COUNT_EN
  localparam bit EXTRA = 1'b1;
`else
  localparam bit EXTRA = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, host_valid, host_ready, imem_we, dmem_we, mem_sel, core_reset, core_done;
  logic out_valid, out_ready, busy, cnt_err, core_dmem_we;
  logic [IW-1:0]  host_data, imem_wdata;
  logic [IAW-1:0] imem_addr, core_imem_addr;
  logic [DAW-1:0] dmem_addr, core_dmem_addr;
  logic [DW-1:0]  dmem_wdata, dmem_rdata, out_data, core_dmem_wdata;

  always #5 clk = ~clk;

  kernel_launcher #(
    .IMEM_ADDR_W(IAW), .INST_W(IW), .DMEM_ADDR_W(DAW), .DATA_W(DW), .DUMP_WORDS(DUMP)
  ) dut (
    .clk(clk), .reset(reset), .host_valid(host_valid), .host_ready(host_ready),
    .host_data(host_data), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .mem_sel(mem_sel), .core_reset(core_reset), .core_done(core_done), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .cnt_err(cnt_err),
    .core_imem_addr(core_imem_addr), .core_dmem_we(core_dmem_we),
    .core_dmem_addr(core_dmem_addr), .core_dmem_wdata(core_dmem_wdata)
  );

  // DMem model: synchronous read, preset contents on the first cycle
  logic [DW-1:0] dmem [0:255];
  bit mem_inited = 1'b0;
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 16'(16'h1000 + i);
      mem_inited <= 1'b1;
    end else if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    dmem_rdata <= dmem[dmem_addr];
  end

  int checks = 0, errors = 0;
  logic [IAW+IW-1:0] exp_iw [$];
  logic [DAW+DW-1:0] exp_dw [$];
  logic [DW-1:0]     exp_out [$];
  logic [DW-1:0]     shadow [0:255];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h, required nothing", name, act);
  endtask

  // monitor: pops the scoreboard on every write and dump transfer
  int nxfer = 0, lowcnt = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [DW-1:0] pd = '0;
  logic [IAW+IW-1:0] e_iw;
  logic [DAW+DW-1:0] e_dw;
  logic [DW-1:0]     e_out;
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_iw.size() == 0) fail("imem unexpected write", {imem_addr, imem_wdata});
      else begin e_iw = exp_iw.pop_front(); chk("imem write", {imem_addr, imem_wdata}, e_iw); end
    end
    if (mem_sel && dmem_we) begin
      if (exp_dw.size() == 0) fail("dmem unexpected write", {dmem_addr, dmem_wdata});
      else begin e_dw = exp_dw.pop_front(); chk("dmem write", {dmem_addr, dmem_wdata}, e_dw); end
    end
    if (core_reset === 1'b0) lowcnt++;
    if (pv && !pr) chk("dump hold", {out_valid, out_data}, {1'b1, pd});
    if (out_valid && out_ready) begin
      if (exp_out.size() == 0) fail("dump extra word", out_data);
      else begin e_out = exp_out.pop_front(); chk("dump word", out_data, e_out); end
      nxfer++;
    end
    pv = out_valid; pr = out_ready; pd = out_data;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] w);
    int t = 0;
    host_valid = 1'b1;
    host_data  = w;
    while (!host_ready && t < 50) begin step(); t++; end
    if (!host_ready) fail("host_ready timeout", t);
    step();
  endtask

  task automatic load_i(input int n, input logic [31:0] base);
    send(32'(n));
    for (int k = 0; k < n; k++) begin
      if (k < 256) exp_iw.push_back({8'(k), base + 32'(k)});
      send(base + 32'(k));
    end
  endtask

  task automatic load_d(input int n, input logic [15:0] base);
    send(32'(n));
    for (int k = 0; k < n; k++) begin
      logic [15:0] w;
      w = base + 16'(2 * k);
      exp_dw.push_back({8'(k), w});
      shadow[k] = w;
      send({16'h0, w});
    end
  endtask

  task automatic run_core(input int n);
    int t = 0;
    int base;
    base = lowcnt;
    while (core_reset && t < 50) begin step(); t++; end
    if (core_reset) fail("core release timeout", t);
    chk("run ports", {mem_sel, host_ready, busy, imem_addr, dmem_addr, dmem_we},
        {1'b0, 1'b0, 1'b1, 8'h55, 8'd200, 1'b1});
    repeat (n) step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("core re-held", {core_reset, mem_sel}, 2'b11);
    chk("run window", lowcnt - base, n + 1);
  endtask

  task automatic dump(input int ncyc, input bit bp);
    int t = 0;
    int base;
    bit did;
    did = !bp;
    base = nxfer;
    for (int i = 0; i < DUMP; i++) exp_out.push_back(shadow[i]);
    if (EXTRA) begin
      exp_out.push_back(16'(ncyc));
      exp_out.push_back(16'(ncyc >>> 16));
    end
    while (busy && t < 1000) begin
      if (!did && out_valid && nxfer == base + 1) begin
        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
        did = 1'b1;
      end
      step();
      t++;
    end
    chk("dump drained", exp_out.size(), 0);
    chk("idle after dump", {busy, out_valid, host_ready}, 3'b001);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 16'(16'h1000 + i);
    reset = 1'b0; host_valid = 1'b1; host_data = 32'h5;
    core_done = 1'b0; out_ready = 1'b1;
    core_imem_addr = 8'h55; core_dmem_we = 1'b1; core_dmem_addr = 8'd200; core_dmem_wdata = 16'hBEEF;

    // reset with a valid host word pending
    step(); step();
    chk("reset flags", {host_ready, core_reset, mem_sel, busy, cnt_err, out_valid, imem_we, dmem_we},
        8'b11100000);
    chk("reset addr", {imem_addr, dmem_addr, out_data}, 0);
    chk("reset wdata", {imem_wdata, dmem_wdata}, 0);
    reset = 1'b1; host_valid = 1'b0;
    step();

    // N=3, M=2, 10-cycle run, backpressure on dump word 1
    load_i(3, 32'hA1);
    load_d(2, 16'd5);
    host_valid = 1'b0;
    run_core(10);
    dump(10, 1'b1);
    chk("no count error", cnt_err, 0);

    // empty images; core_done during the core_reset cycle must be ignored
    send(0); send(0);
    host_valid = 1'b0;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    run_core(3);
    dump(3, 1'b0);

    // IMem overflow: 257 words, last one discarded
    load_i(257, 32'hC000_0000);
    chk("cnt_err set", cnt_err, 1);
    send(0);
    host_valid = 1'b0;
    run_core(5);
    dump(5, 1'b0);
    chk("cnt_err sticky", cnt_err, 1);

    // reset while data word 1 is offered
    send(0); send(3);
    exp_dw.push_back({8'd0, 16'h0011});
    shadow[0] = 16'h0011;
    send(32'h11);
    host_data = 32'h22;
    reset = 1'b0;
    step(); step();
    chk("mid reset", {busy, core_reset, host_ready, dmem_we, cnt_err}, 5'b01100);
    reset = 1'b1; host_valid = 1'b0;
    step();

    // long run: cycle count words read 100, 0 when counting is built in
    send(0); send(0);
    host_valid = 1'b0;
    run_core(100);
    dump(100, 1'b0);

    chk("imem queue empty", exp_iw.size(), 0);
    chk("dmem queue empty", exp_dw.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
